serial_sub_ctrl: RTL and testbench

Bit-serial subtraction sequencer. It computes A − B on WIDTH-bit unsigned operands by driving one shared 1-bit subtract cell for WIDTH cycles, one bit pair per cycle, LSB first. The cell is two cascaded half-subtractor stages with a borrow chain. The block owns operand capture, the bit counter, the borrow register and result assembly, and exposes a start/busy/done handshake to the issuing logic.

---
 rtl/serial_sub_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer: computes a - b LSB first, one bit pair per cycle,
// through a two-stage half-subtractor cell with a registered borrow chain.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a0, b0, t, g, d, p, br_next;
    logic [WIDTH-1:0] sd_shift;

    // Shared subtract cell: half subtractor on the operand bits, then on (t, borrow).
    always_comb begin
        a0       = sa_q[0];
        b0       = sb_q[0];
        t        = a0 ^ b0;
        g        = ~a0 & b0;
        d        = t ^ br_q;
        p        = ~t & br_q;
        br_next  = g | p;
        sd_shift = (sd_q >> 1) | {d, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    sd_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // Result registers take the fully shifted value, including this bit.
                if (cnt_q == LAST) begin
                    diff_d   = sd_shift;
                    borrow_d = br_next;
                    zero_d   = (sd_shift == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: expected results queued at issue, checked on done.
module tb_serial_sub_ctrl;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PERIOD = WIDTH + 2;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
    } res_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    res_t        exp_q[$];
    res_t        mon_exp, mon_got;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned done_count  = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        res_t r;
        r.diff   = x - y;
        r.borrow = (x < y);
        r.zero   = (r.diff == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Result checker: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            vectors++;
            mon_got = {diff, borrow_out, zero};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got %h with no expected result queued", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL result: diff=%h borrow=%b zero=%b expected diff=%h borrow=%b zero=%b",
                             diff, borrow_out, zero, mon_exp.diff, mon_exp.borrow, mon_exp.zero);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h3C;
        tick();
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (diff !== '0) begin miscompares++; $display("FAIL reset_diff: got %h expected 00", diff); end
        vectors++; if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b expected 1", zero); end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_idle: busy got %b expected 0", busy); end
        end
    endtask

    task automatic test_single(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        res_t e;
        res_t prev;
        e    = model(x, y);
        prev = {diff, borrow_out, zero};
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept: busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || done !== (k == WIDTH)) begin
                miscompares++;
                $display("FAIL single_timing: edge E0+%0d busy=%b done=%b expected busy=1 done=%b",
                         k, busy, done, (k == WIDTH));
            end
            if (k < WIDTH) begin
                vectors++;
                if ({diff, borrow_out, zero} !== prev) begin
                    miscompares++;
                    $display("FAIL single_no_partial: edge E0+%0d got %h expected %h", k, {diff, borrow_out, zero}, prev);
                end
            end
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_return_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        tick();
        vectors++;
        if ({diff, borrow_out, zero} !== e) begin
            miscompares++;
            $display("FAIL single_hold: got %h expected %h", {diff, borrow_out, zero}, e);
        end
    endtask

    task automatic test_ignored_start();
        int unsigned c0;
        res_t        e;
        c0 = done_count;
        e  = model(8'h80, 8'h01);
        a     = 8'h80;
        b     = 8'h01;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_done_cycle: done=%b busy=%b expected 1 1", done, busy);
        end
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start_in_done: busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_restart: busy got %b expected 0", busy); end
        tick();
        vectors++;
        if (done_count !== c0 + 1) begin
            miscompares++;
            $display("FAIL ignore_one_done: got %0d pulses expected 1", done_count - c0);
        end
        vectors++;
        if ({diff, borrow_out, zero} !== e) begin
            miscompares++;
            $display("FAIL ignore_result: got %h expected %h", {diff, borrow_out, zero}, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned c0;
        c0 = done_count;
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", done); end
        vectors++; if (diff !== '0) begin miscompares++; $display("FAIL midreset_diff: got %h expected 00", diff); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL midreset_zero: got %b expected 1", zero); end
        vectors++; if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL midreset_borrow: got %b expected 0", borrow_out); end
        rst_n = 1'b1;
        for (int unsigned i = 0; i < PERIOD; i++) tick();
        vectors++;
        if (done_count !== c0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", done_count - c0);
        end
        test_single(8'h10, 8'h20);
    endtask

    task automatic test_back_to_back(input int unsigned n_ops);
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
        start = 1'b1;
        for (int unsigned op = 0; op < n_ops; op++) begin
            for (int unsigned p = 0; p < PERIOD; p++) begin
                if (p == 0) exp_q.push_back(model(a, b));
                tick();
                vectors++;
                if (busy !== (p != WIDTH + 1) || done !== (p == WIDTH)) begin
                    miscompares++;
                    $display("FAIL b2b_cadence: op %0d edge E0+%0d busy=%b done=%b expected busy=%b done=%b",
                             op, p, busy, done, (p != WIDTH + 1), (p == WIDTH));
                end
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single(8'h05, 8'h03);
        test_single(8'h03, 8'h05);
        test_single(8'h00, 8'hFF);
        test_single(8'hA5, 8'hA5);
        test_single(8'hFF, 8'h00);
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back(20);
        test_back_to_back(500);
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results never produced, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
